expr_arbiter: RTL and testbench

Round-robin scheduler that shares one single-digit expression checker between two ASCII byte sources. It grants one source for a whole `;`-terminated expression and forwards its bytes through an internal recognizer. The recognizer implements the grammar digit ((`+`|`*`) digit)*. For each expression it returns a verdict record (ok, source, length) over a valid/ready result port. It sits between the character input streams and the downstream result consumer.

---
 rtl/expr_arbiter_if.sv | 25 ++
 rtl/expr_arbiter.sv | 103 ++++++++++
 tb/tb_expr_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/expr_arbiter_if.sv
// Handshake bundle between the two byte sources, the shared checker and the verdict consumer.
interface expr_arbiter_if;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       res_valid;
  logic       res_ready;
  logic       res_ok;
  logic       res_src;
  logic [7:0] res_len;
  logic [1:0] grant;

  modport master (
    output a_valid, a_data, b_valid, b_data, res_ready,
    input  a_ready, b_ready, res_valid, res_ok, res_src, res_len, grant
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, res_ready,
    output a_ready, b_ready, res_valid, res_ok, res_src, res_len, grant
  );
endinterface

// File: rtl/expr_arbiter.sv
// Round-robin owner of a digit((+|*)digit)* recognizer shared by two ASCII sources;
// emits one (ok, src, len) verdict per ';'-terminated expression.
module expr_arbiter #(
  parameter int unsigned MAXLEN = 32
) (
  input  logic          clk,
  input  logic          clr,
  expr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;
  typedef enum logic [1:0] {EXPECT, AFTER, ERR} chk_t;

  state_t     state;
  chk_t       chk;
  logic [1:0] grant;
  logic       last_src;
  logic [7:0] len;
  logic       res_ok;
  logic       res_src;
  logic [7:0] res_len;

  logic       in_valid;
  logic [7:0] in_data;
  logic       fire;
  logic       is_digit;
  logic       is_op;
  logic       is_term;

  // Byte path is muxed by the registered grant, so readies never depend on valids.
  always_comb begin
    in_valid = grant[1] ? bus.b_valid : bus.a_valid;
    in_data  = grant[1] ? bus.b_data  : bus.a_data;
    fire     = (state == RUN) && in_valid;
    is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    is_op    = (in_data == 8'h2B) || (in_data == 8'h2A);
    is_term  = (in_data == 8'h3B);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      chk      <= EXPECT;
      grant    <= '0;
      last_src <= 1'b1;
      len      <= '0;
      res_ok   <= 1'b0;
      res_src  <= 1'b0;
      res_len  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.a_valid && (!bus.b_valid || last_src)) begin
            grant    <= 2'b01;
            last_src <= 1'b0;
            state    <= RUN;
            len      <= '0;
            chk      <= EXPECT;
          end else if (bus.b_valid) begin
            grant    <= 2'b10;
            last_src <= 1'b1;
            state    <= RUN;
            len      <= '0;
            chk      <= EXPECT;
          end
        end
        RUN: begin
          if (fire) begin
            if (is_term) begin
              res_ok  <= (chk == AFTER) && ({24'd0, len} <= MAXLEN);
              res_src <= grant[1];
              res_len <= len;
              state   <= RESULT;
            end else begin
              if (len != 8'hFF) len <= len + 8'd1;
              case (chk)
                EXPECT:  chk <= is_digit ? AFTER  : ERR;
                AFTER:   chk <= is_op    ? EXPECT : ERR;
                default: chk <= ERR;
              endcase
            end
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_ready   = (state == RUN) && grant[0];
  assign bus.b_ready   = (state == RUN) && grant[1];
  assign bus.res_valid = (state == RESULT);
  assign bus.res_ok    = res_ok;
  assign bus.res_src   = res_src;
  assign bus.res_len   = res_len;
  assign bus.grant     = grant;

endmodule

// File: tb/tb_expr_arbiter.sv
// Directed plus randomized bench for expr_arbiter; two instances (MAXLEN 32 and 4) share stimulus.
module tb_expr_arbiter;

  typedef struct packed {
    logic       ok;
    logic       ok4;
    logic       src;
    logic [7:0] len;
  } rec_t;

  logic       clk;
  logic       clr;
  logic       a_valid, b_valid, res_ready;
  logic [7:0] a_data, b_data;

  expr_arbiter_if bus1 ();
  expr_arbiter_if bus2 ();

  assign bus1.a_valid = a_valid;  assign bus2.a_valid = a_valid;
  assign bus1.a_data  = a_data;   assign bus2.a_data  = a_data;
  assign bus1.b_valid = b_valid;  assign bus2.b_valid = b_valid;
  assign bus1.b_data  = b_data;   assign bus2.b_data  = b_data;
  assign bus1.res_ready = res_ready;
  assign bus2.res_ready = res_ready;

  expr_arbiter #(.MAXLEN(32)) u_dut  (.clk(clk), .clr(clr), .bus(bus1.slave));
  expr_arbiter #(.MAXLEN(4))  u_dut4 (.clk(clk), .clr(clr), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned nchk  = 0;
  int unsigned nfail = 0;

  logic [7:0] a_q[$], b_q[$], a_cur[$], b_cur[$];
  rec_t       exp_q[$];
  logic       m_last, m_idle;
  logic       pred_g_v, pred_r_v;
  logic [1:0] pred_g;
  logic       stall;
  int         rr_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic rec_t model(input logic [7:0] s[$], input logic src);
    rec_t r;
    int unsigned n = s.size();
    logic legal = (n > 0) && (n % 2 == 1);
    for (int unsigned i = 0; i < n; i++) begin
      if (i % 2 == 0) legal &= (s[i] >= 8'h30) && (s[i] <= 8'h39);
      else            legal &= (s[i] == 8'h2B) || (s[i] == 8'h2A);
    end
    r.ok  = legal && (n <= 32);
    r.ok4 = legal && (n <= 4);
    r.src = src;
    r.len = (n > 255) ? 8'd255 : n[7:0];
    return r;
  endfunction

  task automatic push_byte(input logic src, input logic [7:0] c);
    if (src) b_q.push_back(c); else a_q.push_back(c);
  endtask

  task automatic push_str(input logic src, input string s);
    for (int i = 0; i < s.len(); i++) push_byte(src, s[i]);
  endtask

  task automatic push_rnd(input logic src);
    string       pool = "0123456789+*a-/";
    int unsigned n = $urandom_range(0, 7);
    logic        legal = ($urandom_range(0, 3) != 0);
    for (int unsigned i = 0; i < n; i++) begin
      if (!legal)      push_byte(src, pool[$urandom_range(0, 14)]);
      else if (i % 2 == 0) push_byte(src, 8'h30 + 8'($urandom_range(0, 9)));
      else             push_byte(src, $urandom_range(0, 1) ? 8'h2B : 8'h2A);
    end
    push_byte(src, 8'h3B);
  endtask

  // One cycle: check outputs at negedge, drive inputs, predict, advance to next negedge.
  task automatic step();
    rec_t r;
    logic fa, fb, hs;
    if (pred_g_v) begin chk("grant_arb", bus1.grant, pred_g); pred_g_v = 1'b0; end
    if (pred_r_v) begin chk("res_valid_latency", bus1.res_valid, 1'b1); pred_r_v = 1'b0; end
    if (bus1.res_valid) begin
      if (exp_q.size() == 0) chk("spurious_res_valid", bus1.res_valid, 1'b0);
      else begin
        r = exp_q[0];
        chk("hold_ok", bus1.res_ok, r.ok);
        chk("hold_src", bus1.res_src, r.src);
        chk("hold_len", bus1.res_len, r.len);
        chk("hold_grant", bus1.grant, r.src ? 2'b10 : 2'b01);
        chk("result_readies", {bus1.a_ready, bus1.b_ready}, 2'b00);
      end
    end else if (m_idle) begin
      chk("idle_readies", {bus1.a_ready, bus1.b_ready}, 2'b00);
    end else begin
      chk("run_readies", {bus1.b_ready, bus1.a_ready}, bus1.grant);
    end

    a_valid = (a_q.size() > 0) && (!stall || $urandom_range(0, 3) != 0);
    a_data  = a_valid ? a_q[0] : 8'($urandom);
    b_valid = (b_q.size() > 0) && (!stall || $urandom_range(0, 3) != 0);
    b_data  = b_valid ? b_q[0] : 8'($urandom);
    res_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;

    fa = a_valid && bus1.a_ready;
    fb = b_valid && bus1.b_ready;
    if (fa) begin
      if (a_q[0] == 8'h3B) begin
        exp_q.push_back(model(a_cur, 1'b0)); a_cur.delete(); pred_r_v = 1'b1;
      end else a_cur.push_back(a_q[0]);
      void'(a_q.pop_front());
    end
    if (fb) begin
      if (b_q[0] == 8'h3B) begin
        exp_q.push_back(model(b_cur, 1'b1)); b_cur.delete(); pred_r_v = 1'b1;
      end else b_cur.push_back(b_q[0]);
      void'(b_q.pop_front());
    end

    if (m_idle) begin
      if (a_valid && (!b_valid || m_last)) begin pred_g = 2'b01; m_last = 1'b0; m_idle = 1'b0; end
      else if (b_valid) begin pred_g = 2'b10; m_last = 1'b1; m_idle = 1'b0; end
      else pred_g = 2'b00;
      pred_g_v = 1'b1;
    end

    hs = bus1.res_valid && res_ready;
    if (hs && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("res_ok", bus1.res_ok, r.ok);
      chk("res_src", bus1.res_src, r.src);
      chk("res_len", bus1.res_len, r.len);
      chk("res_ok_maxlen4", bus2.res_ok, r.ok4);
      chk("res_len_maxlen4", bus2.res_len, r.len);
      m_idle = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (!(a_q.size() == 0 && b_q.size() == 0 && exp_q.size() == 0 && m_idle) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) chk("drain_timeout", n, 0);
  endtask

  task automatic do_clr();
    clr = 1'b1; a_valid = 1'b1; b_valid = 1'b1; res_ready = 1'b1;
    a_data = 8'h3B; b_data = 8'h3B;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_q.delete(); b_q.delete(); a_cur.delete(); b_cur.delete(); exp_q.delete();
    m_last = 1'b1; m_idle = 1'b1; pred_g_v = 1'b0; pred_r_v = 1'b0;
    chk("rst_grant", bus1.grant, 2'b00);
    chk("rst_readies", {bus1.a_ready, bus1.b_ready}, 2'b00);
    chk("rst_res_valid", bus1.res_valid, 1'b0);
    chk("rst_res_fields", {bus1.res_ok, bus1.res_src, bus1.res_len}, '0);
    chk("rst_res_fields4", {bus2.res_valid, bus2.res_ok, bus2.res_len}, '0);
  endtask

  initial begin
    int unsigned n;
    clr = 1'b1; a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
    a_data = '0; b_data = '0; stall = 1'b0; rr_mode = 0;
    m_last = 1'b1; m_idle = 1'b1; pred_g_v = 1'b0; pred_r_v = 1'b0; pred_g = '0;
    @(negedge clk);
    do_clr();

    push_str(1'b0, "1+2*3;");
    drain();

    push_str(1'b0, "7;7;"); push_str(1'b1, "7;7;");
    drain();

    push_str(1'b0, "12+3;"); push_str(1'b0, ";"); push_str(1'b0, "1+;"); push_str(1'b0, "a;");
    drain();

    push_str(1'b0, "1+2+3;");
    drain();

    for (int i = 0; i < 300; i++) push_byte(1'b0, (i % 2 == 0) ? 8'h31 : 8'h2B);
    push_byte(1'b0, 8'h3B);
    drain();

    rr_mode = 2;
    push_str(1'b0, "4*5;");
    n = 0;
    while (!bus1.res_valid && n < 20) begin step(); n++; end
    chk("bp_result_seen", bus1.res_valid, 1'b1);
    push_str(1'b1, "9;");
    for (int i = 0; i < 5; i++) step();
    rr_mode = 0;
    drain();

    push_str(1'b0, "1+2;");
    n = 0;
    while (a_cur.size() < 2 && n < 20) begin step(); n++; end
    chk("clr_prefix_seen", a_cur.size(), 2);
    push_str(1'b1, "3;");
    step();
    do_clr();
    for (int i = 0; i < 4; i++) step();
    push_str(1'b0, "5;"); push_str(1'b1, "6;");
    step();
    chk("post_clr_first_grant", pred_g, 2'b01);
    drain();

    for (int k = 0; k < 40; k++) begin
      stall   = 1'($urandom_range(0, 1));
      rr_mode = $urandom_range(0, 1);
      push_rnd(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) != 0) push_rnd(1'($urandom_range(0, 1)));
      if (k % 5 == 4) drain();
    end
    stall = 1'b0; rr_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
